// File: rtl/instruction_fetch.sv
// instruction_fetch: PC holder issuing one instruction read at a time, writing results to the queue,
// with static JAL redirect, full-queue parking and flush with stale-response drop.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        iq_we,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  input  logic        iq_full
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;
  state_t state, nxt;
  logic [31:0] pc, hold_inst, npc, jimm;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (flush)
      nxt = ((state == REQ && mem_req_ready) || ((state == WAIT || state == DROP) && !mem_resp_valid)) ? DROP : REQ;
    else
      case (state)
        IDLE: nxt = REQ;
        REQ:  nxt = mem_req_ready ? WAIT : REQ;
        WAIT: nxt = mem_resp_valid ? (iq_full ? HOLD : REQ) : WAIT;
        HOLD: nxt = iq_full ? HOLD : REQ;
        DROP: nxt = mem_resp_valid ? REQ : DROP;
        default: nxt = IDLE;
      endcase
  end
  always_comb begin
    mem_req_valid = state == REQ;
    mem_req_addr = pc;
    iq_pc = pc;
    iq_inst = state == HOLD ? hold_inst : mem_resp_data;
    iq_we = !flush && !iq_full && (state == HOLD || (state == WAIT && mem_resp_valid));
    jimm = {{11{iq_inst[31]}}, iq_inst[31], iq_inst[19:12], iq_inst[20], iq_inst[30:21], 1'b0};
    npc = pc + (iq_inst[6:0] == 7'b1101111 ? jimm : 32'd4);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      hold_inst <= '0;
    end else if (flush) begin
      pc <= flush_pc;
      hold_inst <= '0;
    end else begin
      if (iq_we) pc <= npc;
      if (state == WAIT && mem_resp_valid && iq_full) hold_inst <= mem_resp_data;
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: latency-programmable memory model with scoreboards for requests and queue writes.
module tb_instruction_fetch;
  logic clk = 0, rst = 1, flush = 0, mem_req_ready = 1, mem_resp_valid = 0, iq_full = 0;
  logic [31:0] flush_pc = 0, mem_resp_data = 0;
  logic mem_req_valid, iq_we;
  logic [31:0] mem_req_addr, iq_inst, iq_pc;
  instruction_fetch dut (.clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .iq_we(iq_we), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_full(iq_full));
  always #5 clk = ~clk;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} wr_t;
  wr_t wq[$];
  logic [31:0] rq[$];
  int nvec = 0, nerr = 0, cyc = 0, last_we = -1, lat = 1, cnt = 0, full_left = 0, w8 = -1;
  bit pend = 0, arm = 0, track_gap = 0;
  logic [31:0] paddr = 0, arm_pc = 0;
  function automatic logic [31:0] word(input logic [31:0] a);
    return a == 32'h10 ? 32'h0100006F : a == 32'h20 ? 32'hFFDFF06F : 32'h00000013;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step;
    bit acc, del;
    logic [31:0] aaddr;
    wr_t e;
    mem_resp_valid = pend && cnt == 0;
    mem_resp_data = mem_resp_valid ? word(paddr) : 32'hDEAD_BEEF;
    if (arm && mem_resp_valid && mem_req_addr == arm_pc) begin full_left = 5; arm = 0; end
    iq_full = full_left > 0;
    @(negedge clk);
    if (iq_we) begin
      if (wq.size() == 0) chk("unexpected_iq_we", iq_pc, 32'hFFFF_FFFF);
      else begin
        e = wq.pop_front();
        chk("iq_pc", iq_pc, e.pc);
        chk("iq_inst", iq_inst, e.inst);
      end
      if (track_gap && last_we >= 0) chk("we_gap", cyc - last_we, 2);
      if (iq_pc == 32'h8) w8 = cyc;
      last_we = cyc;
    end
    acc = mem_req_valid && mem_req_ready;
    aaddr = mem_req_addr;
    del = mem_resp_valid;
    if (acc) begin
      if (rq.size() == 0) chk("unexpected_req", aaddr, 32'hFFFF_FFFF);
      else chk("req_addr", aaddr, rq.pop_front());
      if (pend && !del) chk("req_overlap", 1, 0);
    end
    @(posedge clk); #1;
    cyc++;
    if (full_left > 0) full_left--;
    if (del) pend = 0;
    if (acc) begin pend = 1; cnt = lat - 1; paddr = aaddr; end
    else if (pend && cnt > 0) cnt--;
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic do_reset;
    chk("leftover_writes", wq.size(), 0);
    chk("leftover_reqs", rq.size(), 0);
    wq.delete(); rq.delete();
    rst = 1; flush = 0; mem_req_ready = 1; mem_resp_valid = 0; iq_full = 0;
    mem_resp_data = 32'hA5A5_0001;
    pend = 0; arm = 0; full_left = 0; track_gap = 0;
    @(posedge clk); #1;
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_iq_we", iq_we, 0);
    chk("rst_iq_pc", iq_pc, 0);
    chk("rst_iq_inst", iq_inst, 32'hA5A5_0001);
    @(posedge clk); #1;
    rst = 0; cyc = 0; last_we = -1;
  endtask
  wr_t tbl[9];
  initial begin
    tbl = '{'{32'h00, 32'h13}, '{32'h04, 32'h13}, '{32'h08, 32'h13}, '{32'h0C, 32'h13},
            '{32'h10, 32'h0100006F}, '{32'h20, 32'hFFDFF06F}, '{32'h1C, 32'h13},
            '{32'h20, 32'hFFDFF06F}, '{32'h1C, 32'h13}};
    // straight-line fetch with JAL +16 and JAL -4 at 1-cycle memory
    lat = 1;
    do_reset();
    foreach (tbl[i]) begin wq.push_back(tbl[i]); rq.push_back(tbl[i].pc); end
    track_gap = 1;
    #0 chk("cycle0_valid", mem_req_valid, 0);
    step();
    chk("cycle1_valid", mem_req_valid, 1);
    steps(18);
    // full queue parks the word fetched at 0x8 for five cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin wq.push_back(tbl[i]); rq.push_back(tbl[i].pc); end
    arm = 1; arm_pc = 32'h8; w8 = -1;
    steps(14);
    chk("hold_write_cycle", w8, 11);
    // flush one cycle after acceptance, stale response three cycles later
    lat = 4;
    do_reset();
    rq.push_back(32'h0); rq.push_back(32'h100);
    wq.push_back('{32'h100, 32'h13});
    steps(2);
    flush = 1; flush_pc = 32'h100;
    step();
    flush = 0;
    steps(8);
    // flush coincident with response, restart PC wraps to zero
    lat = 1;
    do_reset();
    rq.push_back(32'h0); rq.push_back(32'hFFFF_FFFC); rq.push_back(32'h0);
    wq.push_back('{32'hFFFF_FFFC, 32'h13});
    steps(2);
    flush = 1; flush_pc = 32'hFFFF_FFFC;
    step();
    flush = 0;
    chk("postflush_valid", mem_req_valid, 1);
    chk("postflush_addr", mem_req_addr, 32'hFFFF_FFFC);
    steps(3);
    // stalled ready then reset while waiting
    lat = 4;
    do_reset();
    rq.push_back(32'h0); rq.push_back(32'h4);
    wq.push_back('{32'h0, 32'h13});
    step();
    mem_req_ready = 0;
    steps(3);
    chk("stall_valid", mem_req_valid, 1);
    chk("stall_addr", mem_req_addr, 0);
    mem_req_ready = 1;
    steps(6);
    #2 rst = 1;
    #1;
    chk("async_rst_valid", mem_req_valid, 0);
    chk("async_rst_addr", mem_req_addr, 0);
    chk("async_rst_iq_pc", iq_pc, 0);
    chk("async_rst_iq_we", iq_we, 0);
    lat = 1;
    do_reset();
    rq.push_back(32'h0);
    wq.push_back('{32'h0, 32'h13});
    steps(3);
    chk("final_writes", wq.size(), 0);
    chk("final_reqs", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
